inst_prefetch_source: RTL and testbench
=======================================

// Module: inst_prefetch_source
// PURPOSE
//  Instruction-supply end of the fetch valid/ready interface: generates the sequential PC and
//  issues requests to a synchronous 1-cycle instruction ROM. Buffers returned words in a small
//  FIFO and presents {pc, inst} to the fetch stage via valid_o/ready_i.
//  Sits between the instruction memory and the fetch unit; jump redirect flushes all queued
//  and in-flight words.
// PARAMETERS
//  RESET_PC   32'h8000_0000  first fetch address after reset (word aligned)
//  DEPTH      4              FIFO entries; power of 2, >= 2
// PORTS
//  clk          in   1   clock
//  reset_n      in   1   asynchronous active-low reset
//  jump_flag_i  in   1   redirect request from execute; single-cycle pulse, may repeat
//  jump_addr_i  in   32  redirect target; bits [1:0] ignored (forced 0)
//  mem_req_o    out  1   ROM read request this cycle
//  mem_addr_o   out  32  ROM read address (word aligned)
//  mem_rdata_i  in   32  ROM data; valid the cycle after mem_req_o
//  valid_o      out  1   head entry available to fetch stage
//  ready_i      in   1   fetch stage accepts head entry
//  inst_o       out  32  head instruction word
//  pc_o         out  32  address of inst_o
//  count_o      out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (async, reset_n=0): pc_r=RESET_PC, count=0, inflight=0, FIFO pointers 0.
//   - mem_req_o=0, valid_o=0, inst_o=0, pc_o=0, count_o=0 while reset_n is low.
//  Credit: credit = count + inflight.
//   - mem_req_o = (credit < DEPTH) | jump_flag_i.
//   - FIFO never overflows; the ROM is never stalled (no ready on the ROM side).
//  Sequential issue (jump_flag_i=0): mem_addr_o=pc_r.
//   - On mem_req_o: pc_r <= pc_r+4 (mod 2^32), inflight <= 1, inflight_pc <= pc_r.
//   - Otherwise inflight <= 0.
//  Response: cycle after an issue, if inflight=1 and jump_flag_i=0,
//   push {inflight_pc, mem_rdata_i}.
//  Output: valid_o = (count!=0) & ~jump_flag_i.
//   - inst_o/pc_o = head entry, combinational from registered storage; 0 when empty.
//   - Pop when valid_o & ready_i.
//  Push and pop in the same cycle: count unchanged, both pointers advance (mod DEPTH).
//  Jump cycle (jump_flag_i=1), highest priority:
//   - FIFO cleared (count <= 0, pointers <= 0); the current inflight response is discarded.
//   - No pop.
//   - mem_addr_o = {jump_addr_i[31:2],2'b0}, mem_req_o=1.
//   - pc_r <= target+4; inflight <= 1 with inflight_pc <= target.
//  Latency: request-to-valid 2 cycles.
//   - First valid_o is 2 cycles after reset release.
//   - Redirect-to-valid is 2 cycles after the jump cycle.
//  Back-to-back jumps: each jump flushes the previous target's in-flight word; the last one wins.
//  Full with ready_i=0: mem_req_o=0, entries held stable, pc_r held.
//  Reset mid-operation: all state returns to reset values immediately; no partial pushes.
// TESTING
//  1 Reset release, ready_i=1, ROM[a]=a^32'hFFFF -> valid_o at cycle 2.
//    Stream pc_o 8000_0000, 8000_0004, ... one per cycle; inst_o matches ROM.
//  2 ready_i=0 from reset -> count_o saturates at 4.
//    mem_req_o low thereafter; pc_o=8000_0000 held.
//    ready_i=1 -> 4 pops, then streaming resumes at 8000_0010 gap-free.
//  3 Jump to 0000_1002 with FIFO holding 3 entries -> valid_o=0 in jump cycle and next.
//    count_o=0; pc_o=0000_1000 valid 2 cycles later; no stale word delivered.
//  4 Jumps on two consecutive cycles (0x100 then 0x200) -> no 0x100 word ever delivered.
//    First output pc_o=0x200.
//  5 pc_r at FFFF_FFFC after jump -> next pc_o=0000_0000 (wrap).
//  6 reset_n asserted mid-stream with FIFO full -> outputs 0 immediately.
//    After release, first pc_o=8000_0000.

Source files
------------

// File: rtl/inst_prefetch_source.sv
// Instruction prefetch source: issues sequential PCs to a 1-cycle synchronous ROM and
// buffers {pc, inst} in a DEPTH-entry FIFO toward the fetch stage (valid/ready).
// Latency: request-to-valid 2 cycles; redirect-to-valid 2 cycles after the jump cycle.
// Backpressure: ROM requests are credit-limited (count + inflight < DEPTH) so the ROM never stalls.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   jump_flag_i, jump_addr_i      redirect pulse and target (bits [1:0] ignored)
//   mem_req_o, mem_addr_o         ROM read request / word address
//   mem_rdata_i                   ROM data, valid the cycle after mem_req_o
//   valid_o, ready_i              fetch-side handshake
//   inst_o, pc_o, count_o         head entry and FIFO occupancy
module inst_prefetch_source #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       jump_flag_i,
  input  logic [31:0]                jump_addr_i,
  output logic                       mem_req_o,
  output logic [31:0]                mem_addr_o,
  input  logic [31:0]                mem_rdata_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [31:0]                inst_o,
  output logic [31:0]                pc_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic [31:0]   jump_target;
  logic [CW:0]   credit;
  logic          has_credit;
  logic          push;
  logic          pop;
  logic          not_empty;
  logic          unused_addr_lsbs;

  // Low address bits of the redirect target are dropped by design.
  assign unused_addr_lsbs = ^jump_addr_i[1:0];

  assign jump_target = {jump_addr_i[31:2], 2'b00};
  assign credit      = (CW+1)'(count_q) + (CW+1)'(inflight_q);
  assign has_credit  = credit < DEPTH_C;
  assign not_empty   = count_q != '0;

  // A redirect always issues, even without credit: the flush frees every slot.
  assign mem_req_o  = reset_n & (has_credit | jump_flag_i);
  assign mem_addr_o = jump_flag_i ? jump_target : pc_q;

  // The word returning during a jump cycle belongs to the old stream and is dropped.
  assign push    = inflight_q & ~jump_flag_i;
  assign valid_o = not_empty & ~jump_flag_i;
  assign pop     = valid_o & ready_i;

  assign inst_o  = not_empty ? inst_mem_q[rd_ptr_q] : 32'h0;
  assign pc_o    = not_empty ? pc_mem_q[rd_ptr_q]   : 32'h0;
  assign count_o = count_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (jump_flag_i) begin
      pc_d          = jump_target + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = jump_target;
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
    end else begin
      if (has_credit) begin
        pc_d          = pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= 32'h0;
        inst_mem_q[i] <= 32'h0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
      inst_mem_q[wr_ptr_q] <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_source.sv
module tb_inst_prefetch_source;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [2:0]  count_o;

  int n_pass = 0;
  int n_chk  = 0;
  logic saw_100 = 1'b0;

  always #5 clk = ~clk;

  inst_prefetch_source #(.RESET_PC(32'h8000_0000), .DEPTH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .jump_flag_i (jump_flag_i),
    .jump_addr_i (jump_addr_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .inst_o      (inst_o),
    .pc_o        (pc_o),
    .count_o     (count_o)
  );

  // ROM: word at address a holds a ^ 32'hFFFF, one-cycle synchronous read.
  always @(posedge clk) mem_rdata_i <= mem_addr_o ^ 32'h0000_FFFF;

  // Record any delivered word from the first (flushed) target of the double jump.
  always @(negedge clk)
    if (reset_n && valid_o && ready_i && pc_o == 32'h0000_0100) saw_100 <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_pc"}, pc_o, pc);
    chk({tag, "_inst"}, inst_o, pc ^ 32'h0000_FFFF);
  endtask

  initial begin
    reset_n     = 1'b0;
    jump_flag_i = 1'b0;
    jump_addr_i = 32'h0;
    ready_i     = 1'b1;
    step();
    step();
    #1;
    chk("rst_req",   32'(mem_req_o), 32'd0);
    chk("rst_valid", 32'(valid_o),   32'd0);
    chk("rst_count", 32'(count_o),   32'd0);
    chk("rst_pc",    pc_o,           32'd0);
    chk("rst_inst",  inst_o,         32'd0);

    // 1: release, first valid two cycles later, then one word per cycle
    step();
    reset_n = 1'b1;
    #1;
    chk("t1_c0_req",   32'(mem_req_o), 32'd1);
    chk("t1_c0_addr",  mem_addr_o,     32'h8000_0000);
    chk("t1_c0_valid", 32'(valid_o),   32'd0);
    step();
    chk("t1_c1_valid", 32'(valid_o),   32'd0);
    step();
    chk_head("t1_c2", 32'h8000_0000);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk_head("t1_stream", 32'h8000_0000 + 32'(4 * k));
    end

    // 2: reset mid-stream, then hold ready low until the FIFO saturates
    reset_n = 1'b0;
    ready_i = 1'b0;
    #1;
    chk("t2_rst_valid", 32'(valid_o), 32'd0);
    chk("t2_rst_pc",    pc_o,         32'd0);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("t2_full_count", 32'(count_o),   32'd4);
    chk("t2_full_req",   32'(mem_req_o), 32'd0);
    chk_head("t2_full_hold", 32'h8000_0000);
    step();
    step();
    chk("t2_held_count", 32'(count_o), 32'd4);
    chk("t2_held_pc",    pc_o,         32'h8000_0000);
    ready_i = 1'b1;
    #1;
    chk_head("t2_drain0", 32'h8000_0000);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_head("t2_drain", 32'h8000_0000 + 32'(4 * k));
    end

    // 3: jump with three entries queued
    reset_n = 1'b0;
    ready_i = 1'b0;
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("t3_pre_count", 32'(count_o), 32'd3);
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_1002;
    #1;
    chk("t3_j_valid", 32'(valid_o),   32'd0);
    chk("t3_j_req",   32'(mem_req_o), 32'd1);
    chk("t3_j_addr",  mem_addr_o,     32'h0000_1000);
    step();
    jump_flag_i = 1'b0;
    ready_i     = 1'b1;
    #1;
    chk("t3_j1_valid", 32'(valid_o), 32'd0);
    chk("t3_j1_count", 32'(count_o), 32'd0);
    step();
    chk_head("t3_j2", 32'h0000_1000);
    step();
    chk_head("t3_j3", 32'h0000_1004);

    // 4: back-to-back jumps, the second wins
    step();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h0000_0100;
    #1;
    chk("t4_j1_addr", mem_addr_o, 32'h0000_0100);
    step();
    jump_addr_i = 32'h0000_0200;
    #1;
    chk("t4_j2_addr",  mem_addr_o,   32'h0000_0200);
    chk("t4_j2_valid", 32'(valid_o), 32'd0);
    step();
    jump_flag_i = 1'b0;
    #1;
    chk("t4_gap_valid", 32'(valid_o), 32'd0);
    step();
    chk_head("t4_first", 32'h0000_0200);
    step();
    chk_head("t4_second", 32'h0000_0204);
    step();
    chk("t4_no_100", 32'(saw_100), 32'd0);

    // 5: address wrap past the top of memory
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFFF;
    #1;
    chk("t5_j_addr", mem_addr_o, 32'hFFFF_FFFC);
    step();
    jump_flag_i = 1'b0;
    step();
    chk_head("t5_top", 32'hFFFF_FFFC);
    step();
    chk_head("t5_wrap", 32'h0000_0000);
    step();
    chk_head("t5_next", 32'h0000_0004);

    // 6: reset with the FIFO full
    ready_i = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk("t6_full_count", 32'(count_o), 32'd4);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(valid_o),   32'd0);
    chk("t6_rst_count", 32'(count_o),   32'd0);
    chk("t6_rst_req",   32'(mem_req_o), 32'd0);
    chk("t6_rst_pc",    pc_o,           32'd0);
    chk("t6_rst_inst",  inst_o,         32'd0);
    step();
    reset_n = 1'b1;
    ready_i = 1'b1;
    step();
    chk("t6_c1_valid", 32'(valid_o), 32'd0);
    step();
    chk_head("t6_first", 32'h8000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
